config_frame_writer: RTL and testbench

- Bitstream-side driver of the tile configuration frame interface.
- Accepts 32-bit configuration words over a valid/ready stream and assembles one full frame, one word per row, onto FrameData.
- Then pulses exactly one FrameStrobe bit so the addressed column's config latches capture that frame.
- Sits between the fabric-level bitstream source (UART/SPI loader) and the column FrameStrobe/row FrameData distribution.

---
 rtl/config_frame_writer_if.sv | 27 ++
 rtl/config_frame_writer.sv | 154 +++++++++++++++
 tb/tb_config_frame_writer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_frame_writer_if.sv
// Configuration frame bus: word stream from the bitstream loader plus the
// assembled frame, column strobe and status flags heading to the fabric.
// master = bitstream source side, slave = frame writer side.
interface config_frame_writer_if #(
  parameter int FrameBitsPerRow = 32,
  parameter int NumberOfRows    = 16,
  parameter int MaxFramesPerCol = 20,
  parameter int NumberOfCols    = 8
);
  logic [31:0]                               WriteData;
  logic                                      WriteStrobe;
  logic                                      WriteReady;
  logic [FrameBitsPerRow*NumberOfRows-1:0]   FrameData;
  logic [MaxFramesPerCol*NumberOfCols-1:0]   FrameStrobe;
  logic                                      Busy;
  logic                                      Error;

  modport master (
    output WriteData, WriteStrobe,
    input  WriteReady, FrameData, FrameStrobe, Busy, Error
  );

  modport slave (
    input  WriteData, WriteStrobe,
    output WriteReady, FrameData, FrameStrobe, Busy, Error
  );
endinterface

// File: rtl/config_frame_writer.sv
// Configuration frame writer: waits for SyncWord, takes a header (column and
// frame address), collects NumberOfRows row words into FrameData, then fires a
// single-cycle one-hot FrameStrobe for the addressed column/frame followed by a
// guard cycle so the column latches see stable data around the strobe.
// Optional build macro: CONFIG_FRAME_CHECK_EN adds a trailer word that must
// equal the XOR of all row words; a mismatch suppresses the strobe.
module config_frame_writer #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          NumberOfRows    = 16,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumberOfCols    = 8,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input logic                   CLK,
  input logic                   RST,
  config_frame_writer_if.slave  bus
);

  localparam int FRAME_W  = FrameBitsPerRow * NumberOfRows;
  localparam int STROBE_W = MaxFramesPerCol * NumberOfCols;
  localparam int ROW_W    = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_DATA, S_CHECK, S_STROBE, S_GUARD
  } state_t;

  state_t                state_q;
  logic [ROW_W-1:0]      row_q;
  logic [7:0]            col_q;
  logic [4:0]            frame_q;
  logic [FRAME_W-1:0]    frame_data_q;
  logic [STROBE_W-1:0]   strobe_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  err_q;
`ifdef CONFIG_FRAME_CHECK_EN
  logic [31:0]           xor_q;
`endif

  logic                  accept;
  logic                  addr_ok;
  logic                  fire_ok;
  logic                  last_row;
  int                    slot;
  int                    strobe_idx;
  logic [STROBE_W-1:0]   strobe_d;

  // Handshake, address range check and one-hot strobe pattern for the current frame.
  always_comb begin
    accept     = bus.WriteStrobe && ready_q;
    addr_ok    = (int'(col_q) < NumberOfCols) && (int'(frame_q) < MaxFramesPerCol);
    strobe_idx = int'(col_q) * MaxFramesPerCol + int'(frame_q);
    strobe_d   = STROBE_W'(1) << strobe_idx;
    slot       = (NumberOfRows - 1) - int'(row_q);
    last_row   = (row_q == ROW_W'(NumberOfRows - 1));
`ifdef CONFIG_FRAME_CHECK_EN
    fire_ok    = addr_ok && (bus.WriteData == xor_q);
`else
    fire_ok    = addr_ok;
`endif
  end

  // Session FSM with registered outputs; strobe is cleared every cycle unless fired.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      frame_q      <= '0;
      frame_data_q <= '0;
      strobe_q     <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
`ifdef CONFIG_FRAME_CHECK_EN
      xor_q        <= '0;
`endif
    end else begin
      strobe_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (accept && (bus.WriteData == SyncWord)) begin
            state_q <= S_HEADER;
            busy_q  <= 1'b1;
          end
        end
        S_HEADER: begin
          if (accept) begin
            if (bus.WriteData[31]) begin
              // Desync: back to hunting for SyncWord, Error left as is.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              col_q   <= bus.WriteData[15:8];
              frame_q <= bus.WriteData[4:0];
              row_q   <= '0;
`ifdef CONFIG_FRAME_CHECK_EN
              xor_q   <= '0;
`endif
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            frame_data_q[slot*FrameBitsPerRow +: FrameBitsPerRow] <= bus.WriteData;
            row_q <= row_q + ROW_W'(1);
`ifdef CONFIG_FRAME_CHECK_EN
            xor_q <= xor_q ^ bus.WriteData;
            if (last_row) state_q <= S_CHECK;
`else
            if (last_row) begin
              state_q <= S_STROBE;
              ready_q <= 1'b0;
              if (fire_ok) strobe_q <= strobe_d;
              else         err_q    <= 1'b1;
            end
`endif
          end
        end
`ifdef CONFIG_FRAME_CHECK_EN
        S_CHECK: begin
          if (accept) begin
            state_q <= S_STROBE;
            ready_q <= 1'b0;
            if (fire_ok) strobe_q <= strobe_d;
            else         err_q    <= 1'b1;
          end
        end
`endif
        S_STROBE: begin
          state_q <= S_GUARD;
        end
        S_GUARD: begin
          // FrameData held one more cycle after the strobe for latch hold time.
          state_q <= S_HEADER;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.WriteReady  = ready_q;
  assign bus.FrameData   = frame_data_q;
  assign bus.FrameStrobe = strobe_q;
  assign bus.Busy        = busy_q;
  assign bus.Error       = err_q;

endmodule

// File: tb/tb_config_frame_writer.sv
// Bench for config_frame_writer: randomized frames against a row-array model.
module tb_config_frame_writer;

  localparam int ROWS = 16;
  localparam int FPC  = 20;
  localparam int COLS = 8;
  localparam int FW   = 32 * ROWS;
  localparam int SW   = FPC * COLS;
  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  config_frame_writer_if #(.FrameBitsPerRow(32), .NumberOfRows(ROWS),
                           .MaxFramesPerCol(FPC), .NumberOfCols(COLS)) bus ();

  config_frame_writer #(.FrameBitsPerRow(32), .NumberOfRows(ROWS),
                        .MaxFramesPerCol(FPC), .NumberOfCols(COLS),
                        .SyncWord(SYNC)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  // Reference model: row words of the most recently written frame, sticky error.
  logic [31:0] exp_rows [ROWS];
  bit          exp_err;

  // Strobe observations.
  int              strobe_idx_q [$];
  int              strobe_cyc_q [$];
  logic [FW-1:0]   strobe_data_q [$];
  int              strobe_multi = 0;
  int              ready_low = 0;

  always @(posedge CLK) cyc++;

  always @(negedge CLK) begin
    if (bus.FrameStrobe != '0) begin
      if ($countones(bus.FrameStrobe) != 1) strobe_multi++;
      for (int i = 0; i < SW; i++) if (bus.FrameStrobe[i]) strobe_idx_q.push_back(i);
      strobe_cyc_q.push_back(cyc);
      strobe_data_q.push_back(bus.FrameData);
    end
    if (!bus.WriteReady) ready_low++;
  end

  function automatic logic [FW-1:0] exp_frame();
    logic [FW-1:0] f = '0;
    for (int r = 0; r < ROWS; r++) f = {f[FW-33:0], exp_rows[r]};
    return f;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++) exp_rows[r] = '0;
    exp_err = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    bit done = 0;
    for (int t = 0; t < 16 && !done; t++) begin
      @(negedge CLK);
      bus.WriteStrobe = 1'b1;
      bus.WriteData   = w;
      if (bus.WriteReady) begin
        @(posedge CLK);
        #1;
        last_acc_cyc = cyc;
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL accept_timeout word=%h not accepted within 16 cycles", w);
    end
  endtask

  task automatic release_bus();
    @(negedge CLK);
    bus.WriteStrobe = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input int col, input int frm, input bit rnd, input bit bad,
                            input bit hold, output bit fire, output int idx);
    logic [31:0] hdr, d, x;
    hdr = {1'b0, 15'($urandom), 8'(col), 3'($urandom), 5'(frm)};
    send_word(hdr);
    x = '0;
    for (int i = 0; i < ROWS; i++) begin
      d = rnd ? 32'($urandom) : 32'h1000_0000 + 32'(i);
      send_word(d);
      exp_rows[i] = d;
      x = x ^ d;
    end
`ifdef CONFIG_FRAME_CHECK_EN
    send_word(bad ? (x ^ 32'd1) : x);
    fire = (col < COLS) && (frm < FPC) && !bad;
`else
    fire = (col < COLS) && (frm < FPC) && (bad || !bad);
`endif
    idx = col * FPC + frm;
    if (!fire) exp_err = 1'b1;
    if (!hold) release_bus();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.WriteStrobe = 1'b0;
    bus.WriteData   = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    @(negedge CLK);
    checks += 5;
    if (bus.FrameData !== '0) begin errors++; $display("FAIL reset_framedata got=%h exp=0", bus.FrameData); end
    if (bus.FrameStrobe !== '0) begin errors++; $display("FAIL reset_strobe got=%h exp=0", bus.FrameStrobe); end
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
    if (bus.Error !== 1'b0) begin errors++; $display("FAIL reset_error got=%b exp=0", bus.Error); end
    if (bus.WriteReady !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.WriteReady); end
  endtask

  task automatic test_basic_frame();
    bit fire; int idx, n0, r0;
    send_word(SYNC);
    n0 = strobe_idx_q.size();
    r0 = ready_low;
    send_frame(2, 3, 1'b0, 1'b0, 1'b0, fire, idx);
    idle_cycles(4);
    checks += 9;
    if (strobe_idx_q.size() - n0 !== 1) begin errors++; $display("FAIL basic_strobe_count got=%0d exp=1", strobe_idx_q.size() - n0); end
    if (strobe_idx_q[$] !== 43) begin errors++; $display("FAIL basic_strobe_idx got=%0d exp=43", strobe_idx_q[$]); end
    if (strobe_cyc_q[$] !== last_acc_cyc) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", strobe_cyc_q[$], last_acc_cyc); end
    if (bus.FrameData[FW-1 -: 32] !== 32'h1000_0000) begin errors++; $display("FAIL basic_top_word got=%h exp=10000000", bus.FrameData[FW-1 -: 32]); end
    if (bus.FrameData[31:0] !== 32'h1000_000F) begin errors++; $display("FAIL basic_bottom_word got=%h exp=1000000f", bus.FrameData[31:0]); end
    if (bus.FrameData !== exp_frame()) begin errors++; $display("FAIL basic_frame got=%h exp=%h", bus.FrameData, exp_frame()); end
    if (bus.Error !== 1'b0) begin errors++; $display("FAIL basic_error got=%b exp=0", bus.Error); end
    if (ready_low - r0 !== 2) begin errors++; $display("FAIL basic_ready_low got=%0d exp=2", ready_low - r0); end
    if (bus.Busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after got=%b exp=1", bus.Busy); end
  endtask

  task automatic test_idle_discard();
    logic [FW-1:0] snap;
    snap = exp_frame();
    send_word(32'h8000_0000);
    release_bus();
    checks += 2;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL desync_busy got=%b exp=0", bus.Busy); end
    if (bus.Error !== exp_err) begin errors++; $display("FAIL desync_error got=%b exp=%b", bus.Error, exp_err); end
    send_word(32'h1234_5678);
    send_word(32'hFAB0_FAB0);
    release_bus();
    checks += 3;
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", bus.Busy); end
    if (bus.WriteReady !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", bus.WriteReady); end
    if (bus.FrameData !== snap) begin errors++; $display("FAIL idle_framedata got=%h exp=%h", bus.FrameData, snap); end
    send_word(SYNC);
    release_bus();
    checks++;
    if (bus.Busy !== 1'b1) begin errors++; $display("FAIL sync_busy got=%b exp=1", bus.Busy); end
  endtask

  task automatic test_bad_address();
    bit fire; int idx, n0;
    n0 = strobe_idx_q.size();
    send_frame(8, 0, 1'b1, 1'b0, 1'b0, fire, idx);
    idle_cycles(4);
    send_frame(1, 25, 1'b1, 1'b0, 1'b0, fire, idx);
    idle_cycles(4);
    checks += 3;
    if (strobe_idx_q.size() !== n0) begin errors++; $display("FAIL badaddr_strobe got=%0d exp=%0d", strobe_idx_q.size(), n0); end
    if (bus.Error !== 1'b1) begin errors++; $display("FAIL badaddr_error got=%b exp=1", bus.Error); end
    if (bus.FrameData !== exp_frame()) begin errors++; $display("FAIL badaddr_frame got=%h exp=%h", bus.FrameData, exp_frame()); end
    send_frame(7, 19, 1'b1, 1'b0, 1'b0, fire, idx);
    idle_cycles(4);
    checks += 3;
    if (strobe_idx_q.size() - n0 !== 1) begin errors++; $display("FAIL recover_count got=%0d exp=1", strobe_idx_q.size() - n0); end
    if (strobe_idx_q[$] !== 159) begin errors++; $display("FAIL recover_idx got=%0d exp=159", strobe_idx_q[$]); end
    if (bus.Error !== 1'b1) begin errors++; $display("FAIL error_sticky got=%b exp=1", bus.Error); end
  endtask

  task automatic test_back_to_back();
    bit f1, f2; int i1, i2, n0;
    logic [FW-1:0] d1;
    n0 = strobe_idx_q.size();
    send_frame(0, 5, 1'b1, 1'b0, 1'b1, f1, i1);
    d1 = exp_frame();
    send_frame(4, 11, 1'b1, 1'b0, 1'b1, f2, i2);
    release_bus();
    idle_cycles(4);
    checks += 6;
    if (strobe_idx_q.size() - n0 !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", strobe_idx_q.size() - n0); end
    if (strobe_idx_q[n0] !== i1) begin errors++; $display("FAIL b2b_idx1 got=%0d exp=%0d", strobe_idx_q[n0], i1); end
    if (strobe_data_q[n0] !== d1) begin errors++; $display("FAIL b2b_data1 got=%h exp=%h", strobe_data_q[n0], d1); end
    if (strobe_idx_q[n0+1] !== i2) begin errors++; $display("FAIL b2b_idx2 got=%0d exp=%0d", strobe_idx_q[n0+1], i2); end
    if (strobe_data_q[n0+1] !== exp_frame()) begin errors++; $display("FAIL b2b_data2 got=%h exp=%h", strobe_data_q[n0+1], exp_frame()); end
    if (bus.FrameData !== exp_frame()) begin errors++; $display("FAIL b2b_hold got=%h exp=%h", bus.FrameData, exp_frame()); end
  endtask

  task automatic test_reset_mid_frame();
    bit fire; int idx, n0;
    n0 = strobe_idx_q.size();
    send_word({16'h0, 8'd3, 8'd2});
    for (int i = 0; i < 7; i++) send_word(32'($urandom));
    @(negedge CLK);
    bus.WriteStrobe = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    checks += 5;
    if (bus.FrameData !== '0) begin errors++; $display("FAIL midrst_framedata got=%h exp=0", bus.FrameData); end
    if (bus.Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", bus.Busy); end
    if (bus.Error !== 1'b0) begin errors++; $display("FAIL midrst_error got=%b exp=0", bus.Error); end
    if (bus.WriteReady !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", bus.WriteReady); end
    if (bus.FrameStrobe !== '0) begin errors++; $display("FAIL midrst_strobe got=%h exp=0", bus.FrameStrobe); end
    idle_cycles(20);
    checks++;
    if (strobe_idx_q.size() !== n0) begin errors++; $display("FAIL midrst_nostrobe got=%0d exp=%0d", strobe_idx_q.size(), n0); end
    send_word(SYNC);
    send_frame(3, 2, 1'b1, 1'b0, 1'b0, fire, idx);
    idle_cycles(4);
    checks += 3;
    if (strobe_idx_q.size() - n0 !== 1) begin errors++; $display("FAIL midrst_after_count got=%0d exp=1", strobe_idx_q.size() - n0); end
    if (strobe_idx_q[$] !== 62) begin errors++; $display("FAIL midrst_after_idx got=%0d exp=62", strobe_idx_q[$]); end
    if (strobe_data_q[$] !== exp_frame()) begin errors++; $display("FAIL midrst_after_data got=%h exp=%h", strobe_data_q[$], exp_frame()); end
  endtask

`ifdef CONFIG_FRAME_CHECK_EN
  task automatic test_check();
    bit fire; int idx, n0;
    n0 = strobe_idx_q.size();
    send_frame(6, 7, 1'b1, 1'b0, 1'b0, fire, idx);
    idle_cycles(4);
    checks += 3;
    if (strobe_idx_q.size() - n0 !== 1) begin errors++; $display("FAIL check_good_count got=%0d exp=1", strobe_idx_q.size() - n0); end
    if (strobe_idx_q[$] !== 127) begin errors++; $display("FAIL check_good_idx got=%0d exp=127", strobe_idx_q[$]); end
    if (bus.Error !== 1'b0) begin errors++; $display("FAIL check_good_error got=%b exp=0", bus.Error); end
    send_frame(6, 8, 1'b1, 1'b1, 1'b0, fire, idx);
    idle_cycles(4);
    checks += 2;
    if (strobe_idx_q.size() - n0 !== 1) begin errors++; $display("FAIL check_bad_count got=%0d exp=1", strobe_idx_q.size() - n0); end
    if (bus.Error !== 1'b1) begin errors++; $display("FAIL check_bad_error got=%b exp=1", bus.Error); end
  endtask
`endif

  task automatic test_random_frames();
    bit fire, bad; int col, frm, idx, n0;
    for (int k = 0; k < 8; k++) begin
      col = int'($urandom_range(0, 9));
      frm = int'($urandom_range(0, 23));
      bad = ($urandom_range(0, 3) == 0);
      n0  = strobe_idx_q.size();
      send_frame(col, frm, 1'b1, bad, 1'b0, fire, idx);
      idle_cycles(3);
      checks += 3;
      if (strobe_idx_q.size() - n0 !== int'(fire)) begin errors++; $display("FAIL rand_count k=%0d got=%0d exp=%0d", k, strobe_idx_q.size() - n0, fire); end
      if (bus.Error !== exp_err) begin errors++; $display("FAIL rand_error k=%0d got=%b exp=%b", k, bus.Error, exp_err); end
      if (bus.FrameData !== exp_frame()) begin errors++; $display("FAIL rand_frame k=%0d got=%h exp=%h", k, bus.FrameData, exp_frame()); end
      if (fire && strobe_idx_q.size() > n0) begin
        checks++;
        if (strobe_idx_q[$] !== idx) begin errors++; $display("FAIL rand_idx k=%0d got=%0d exp=%0d", k, strobe_idx_q[$], idx); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_idle_discard();
    test_bad_address();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef CONFIG_FRAME_CHECK_EN
    test_check();
`endif
    test_random_frames();
    checks++;
    if (strobe_multi !== 0) begin errors++; $display("FAIL strobe_onehot got=%0d multi-hot cycles exp=0", strobe_multi); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
